// File: rtl/oled_spi_sink_pkg.sv
// Shared types for the OLED SPI capture block: receive FSM states and FIFO entry layout.
// No logic; constants only.
// Entry layout is {dc, byte[7:0]}.
package oled_spi_sink_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,  // panel logic unpowered or held in reset; sclk ignored
    ST_IDLE  = 2'd1,  // waiting for the first bit of a byte
    ST_SHIFT = 2'd2   // 1..7 bits of the current byte held
  } rx_state_t;

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 1;

endpackage

// File: rtl/oled_spi_sink_if.sv
// Read-side handshake of the captured-byte FIFO.
// Combinational bundle, no latency.
// Head entry is held while rd_valid && !rd_ready.
interface oled_spi_sink_if;
  import oled_spi_sink_pkg::*;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_is_data;
  logic              rd_ready;

  modport master (output rd_valid, output rd_data, output rd_is_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_is_data, output rd_ready);

endinterface

// File: rtl/oled_spi_sink_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and zeroed head when empty.
// Write lands one clock after push; head visible as soon as count is non-zero.
// Push on full is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/oled_spi_sink.sv
// Captures SPI bytes (with dc flag) from an OLED driver into a FIFO readable in the sysclk domain.
// Last sclk rising edge at the pin to rd_valid on an empty FIFO: 4 sysclk cycles.
// Bytes arriving on a full FIFO without a same-cycle pop are dropped and flagged in sticky overflow.
module oled_spi_sink
  import oled_spi_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sysclk,
  input  logic                        cpu_resetn,
  input  logic                        oled_sclk,
  input  logic                        oled_sdin,
  input  logic                        oled_dc,
  input  logic                        oled_res,
  input  logic                        oled_vdd,
  input  logic                        oled_vbat,
  oled_spi_sink_if.master             rd,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        panel_on
);
  // sclk: two sync stages plus one history stage for edge detection.
  // sdin/dc: three stages so the sampled bit lines up with the detected edge.
  logic [2:0] sclk_q, sdin_q, dc_q;
  logic [1:0] res_q, vdd_q, vbat_q;

  rx_state_t   state_q, state_d;
  logic [7:0]  sr;
  logic [2:0]  bit_cnt;
  logic        push_vld;
  logic        push_dc;
  logic        sclk_rise;
  logic        enabled;
  logic        shift_en;
  logic        byte_done;
  logic        pop;
  logic        fifo_full;
  logic [ENTRY_W-1:0] head;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign enabled   = res_q[1] & ~vdd_q[1];
  assign shift_en  = enabled && (state_q != ST_OFF) && sclk_rise;
  assign byte_done = shift_en && (bit_cnt == 3'd7);
  assign panel_on  = res_q[1] & ~vdd_q[1] & ~vbat_q[1];

  // Bring every OLED pin into the sysclk domain.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      sclk_q <= '0;
      sdin_q <= '0;
      dc_q   <= '0;
      res_q  <= '0;
      vdd_q  <= '0;
      vbat_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], oled_sclk};
      sdin_q <= {sdin_q[1:0], oled_sdin};
      dc_q   <= {dc_q[1:0], oled_dc};
      res_q  <= {res_q[0], oled_res};
      vdd_q  <= {vdd_q[0], oled_vdd};
      vbat_q <= {vbat_q[0], oled_vbat};
    end
  end

  // Receive FSM state register.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) state_q <= ST_OFF;
    else             state_q <= state_d;
  end

  // Receive FSM next state; losing power or entering display reset wins over everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (enabled)   state_d = ST_IDLE;
      ST_IDLE:  if (shift_en)  state_d = ST_SHIFT;
      ST_SHIFT: if (byte_done) state_d = ST_IDLE;
      default:                 state_d = ST_OFF;
    endcase
    if (!enabled) state_d = ST_OFF;
  end

  // Shift register and bit counter; the completed byte stays in sr for the push cycle,
  // which is safe because the next sclk edge is at least four sysclk cycles away.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      sr       <= '0;
      bit_cnt  <= '0;
      push_vld <= 1'b0;
      push_dc  <= 1'b0;
    end else begin
      push_vld <= byte_done;
      if (byte_done) push_dc <= dc_q[2];
      if (!enabled || state_q == ST_OFF) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        sr      <= {sr[6:0], sdin_q[2]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Sticky drop flag: a push that the FIFO could not take.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn)                           overflow <= 1'b0;
    else if (push_vld && fifo_full && !pop)    overflow <= 1'b1;
  end

  assign pop           = rd.rd_valid && rd.rd_ready;
  assign rd.rd_valid   = (fifo_count != '0);
  assign rd.rd_data    = head[DATA_W-1:0];
  assign rd.rd_is_data = head[DATA_W];

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sysclk),
    .rst_n    (cpu_resetn),
    .push     (push_vld),
    .push_dat ({push_dc, sr}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed + randomized bench for oled_spi_sink; reference model is a plain byte queue.
// Serial stimulus runs at sysclk/8; outputs sampled 1 time unit after the rising edge.
// Pops are collected by a monitor and compared in order against the model queue.
module tb_oled_spi_sink;
  import oled_spi_sink_pkg::*;

  localparam int DEPTH = 16;

  logic sysclk = 1'b0;
  logic cpu_resetn, oled_sclk, oled_sdin, oled_dc, oled_res, oled_vdd, oled_vbat;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow, panel_on;

  oled_spi_sink_if rd();

  oled_spi_sink #(.FIFO_DEPTH(DEPTH)) dut (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .oled_sclk  (oled_sclk),
    .oled_sdin  (oled_sdin),
    .oled_dc    (oled_dc),
    .oled_res   (oled_res),
    .oled_vdd   (oled_vdd),
    .oled_vbat  (oled_vbat),
    .rd         (rd),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .panel_on   (panel_on)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic       exp_ovf = 1'b0;

  // Record every accepted head entry as {dc, byte}.
  always @(negedge sysclk)
    if (cpu_resetn && rd.rd_valid && rd.rd_ready) got_q.push_back({rd.rd_is_data, rd.rd_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one bit with sclk low for 4 cycles, then raise sclk and return immediately.
  task automatic clk_bit(input logic b, input logic dcv);
    oled_sdin = b;
    oled_dc   = dcv;
    oled_sclk = 1'b0;
    repeat (4) tick();
    oled_sclk = 1'b1;
  endtask

  // Send the top n bits of b, MSB first, each with a full 4-cycle high phase.
  task automatic send_bits(input logic [7:0] b, input int n, input logic dcv);
    for (int i = 0; i < n; i++) begin
      clk_bit(b[7-i], dcv);
      repeat (4) tick();
    end
  endtask

  task automatic model_push(input logic [7:0] b, input logic dcv);
    if (exp_q.size() < DEPTH) exp_q.push_back({dcv, b});
    else                      exp_ovf = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv);
    send_bits(b, 8, dcv);
    model_push(b, dcv);
  endtask

  // Pop everything, then compare the popped sequence with the model.
  task automatic drain(input string tag);
    rd.rd_ready = 1'b1;
    for (int i = 0; i < 2*DEPTH + 4; i++) begin
      if (!rd.rd_valid) break;
      tick();
    end
    rd.rd_ready = 1'b0;
    chk({tag, "_empty"}, 32'(rd.rd_valid), 32'd0);
    chk({tag, "_npop"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_pop"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    cpu_resetn = 1'b0;
    #1;
    chk("rst_valid", 32'(rd.rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    exp_q.delete();
    got_q.delete();
    exp_ovf = 1'b0;
    repeat (2) tick();
    cpu_resetn = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0] b;
    logic       d;
    logic [8:0] exp_pop;
    int         n;

    cpu_resetn  = 1'b0;
    oled_sclk   = 1'b0;
    oled_sdin   = 1'b0;
    oled_dc     = 1'b0;
    oled_res    = 1'b1;
    oled_vdd    = 1'b0;
    oled_vbat   = 1'b0;
    rd.rd_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    chk("reset_valid",   32'(rd.rd_valid), 32'd0);
    chk("reset_count",   32'(fifo_count), 32'd0);
    chk("reset_ovf",     32'(overflow), 32'd0);
    chk("reset_panel",   32'(panel_on), 32'd0);
    chk("reset_data",    32'(rd.rd_data), 32'd0);
    chk("reset_is_data", 32'(rd.rd_is_data), 32'd0);
    cpu_resetn = 1'b1;
    repeat (5) tick();
    chk("panel_on", 32'(panel_on), 32'd1);

    // Single command byte with exact latency from the last sclk edge.
    b = 8'hAE;
    send_bits(b, 7, 1'b0);
    clk_bit(b[0], 1'b0);
    repeat (3) tick();
    chk("lat_before", 32'(rd.rd_valid), 32'd0);
    tick();
    chk("lat_at4", 32'(rd.rd_valid), 32'd1);
    model_push(b, 1'b0);
    chk("ae_data", 32'(rd.rd_data), 32'hAE);
    chk("ae_dc",   32'(rd.rd_is_data), 32'd0);
    chk("ae_count", 32'(fifo_count), 32'd1);
    repeat (4) tick();
    drain("ae");

    // Streaming with the consumer always ready.
    rd.rd_ready = 1'b1;
    send_byte(8'h81, 1'b0);
    send_byte(8'h7F, 1'b0);
    send_byte(8'h55, 1'b1);
    drain("stream");

    // Overflow: 17 bytes into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'(exp_q.size()));
    chk("ovf_flag",  32'(overflow), 32'(exp_ovf));
    repeat (3) tick();
    chk("ovf_hold_data", 32'(rd.rd_data), 32'(exp_q[0][7:0]));
    drain("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();

    // Full FIFO with a pop landing on the same cycle as the push.
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'($urandom));
    b = 8'($urandom);
    d = 1'($urandom);
    send_bits(b, 7, d);
    clk_bit(b[0], d);
    repeat (3) tick();
    rd.rd_ready = 1'b1;
    tick();
    rd.rd_ready = 1'b0;
    repeat (4) tick();
    exp_pop = exp_q.pop_front();
    model_push(b, d);
    chk("fullpp_count", 32'(fifo_count), 32'(exp_q.size()));
    chk("fullpp_ovf",   32'(overflow), 32'd0);
    chk("fullpp_npop",  32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("fullpp_pop", 32'(got_q[0]), 32'(exp_pop));
    got_q.delete();
    drain("fullpp");

    // Partial byte aborted by display reset.
    send_bits(8'($urandom), 5, 1'b0);
    oled_res = 1'b0;
    repeat (4) tick();
    chk("res_panel_off", 32'(panel_on), 32'd0);
    oled_res = 1'b1;
    repeat (4) tick();
    send_byte(8'hA5, 1'b0);
    chk("res_count", 32'(fifo_count), 32'd1);
    drain("res");

    // Randomized burst that always overruns the FIFO.
    n = $urandom_range(17, 20);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'($urandom));
    chk("rand_count", 32'(fifo_count), 32'(exp_q.size()));
    chk("rand_ovf",   32'(overflow), 32'(exp_ovf));
    drain("rand");

    // CPU reset mid-byte with entries queued, then a fresh byte.
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'($urandom));
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    send_bits(8'($urandom), 3, 1'b1);
    do_reset();
    send_byte(8'($urandom), 1'($urandom));
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    drain("post_rst");

    // Logic supply off: no capture, panel reported off.
    oled_vdd = 1'b1;
    repeat (4) tick();
    chk("vdd_panel", 32'(panel_on), 32'd0);
    send_bits(8'($urandom), 8, 1'b0);
    chk("vdd_count", 32'(fifo_count), 32'd0);
    oled_vdd  = 1'b0;
    oled_vbat = 1'b1;
    repeat (4) tick();
    chk("vbat_panel", 32'(panel_on), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oled_spi_sink.md
OLED_SPI_SINK -- requirements
Module: oled_spi_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, power of two >= 4: depth of the captured-byte FIFO.
REQ-002 sysclk  in  1  single system clock, all state on rising edge.
REQ-003 cpu_resetn  in  1  reset, asynchronous, active-low.
REQ-004 oled_sclk  in  1  serial clock from the OLED driver, asynchronous to sysclk, at most sysclk/4.
REQ-005 oled_sdin  in  1  serial data, MSB first, valid on rising edge of oled_sclk.
REQ-006 oled_dc  in  1  0 = command byte, 1 = data byte.
REQ-007 oled_res  in  1  display reset, active-low.
REQ-008 oled_vdd  in  1  logic supply enable, active-low (0 = on).
REQ-009 oled_vbat  in  1  panel supply enable, active-low (0 = on).
REQ-010 rd_valid  out  1  FIFO head entry available.
REQ-011 rd_data  out  8  head byte.
REQ-012 rd_is_data  out  1  head entry's dc flag.
REQ-013 rd_ready  in  1  consumer accepts head; pop when rd_valid && rd_ready.
REQ-014 fifo_count  out  log2(FIFO_DEPTH)+1  occupancy.
REQ-015 overflow  out  1  sticky: a byte was dropped on a full FIFO.
REQ-016 panel_on  out  1  1 when oled_vdd==0 && oled_vbat==0 && oled_res==1 (synchronised).

Function
REQ-017 oled_sclk, oled_sdin, oled_dc, oled_res, oled_vdd, oled_vbat SHALL each pass a 2-flop synchroniser; sdin/dc take one extra stage to align with the sclk edge detector.
REQ-018 A rising edge of synchronised sclk SHALL shift aligned sdin into an 8-bit shift register, MSB first, and increment a 3-bit bit counter.
REQ-019 On the 8th bit the completed byte and dc sampled on that same edge SHALL be pushed to the FIFO one sysclk later; bit counter wraps to 0.
REQ-020 Synchronised oled_res==0 or oled_vdd==1 SHALL clear shift register and bit counter; a partial byte is discarded, FIFO contents retained.
REQ-021 Receive FSM states: OFF (vdd off or res low; ignore sclk), IDLE (bit count 0), SHIFT (1..7 bits held); OFF->IDLE when enabled, IDLE->SHIFT on first edge, SHIFT->IDLE on 8th edge, any->OFF when disabled.
REQ-022 Push on full FIFO SHALL drop the byte, leave FIFO unchanged, set overflow; overflow clears only by reset.
REQ-023 Simultaneous push and pop on full FIFO SHALL perform both (no drop); on empty FIFO push only is effective (no bypass).
REQ-024 rd_valid = (fifo_count != 0); rd_data/rd_is_data SHALL be stable while rd_valid && !rd_ready.
REQ-025 Latency: last sclk rising edge at pin to rd_valid high on empty FIFO SHALL be 4 sysclk cycles exactly.
REQ-026 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Reset
REQ-027 On cpu_resetn low, all synchronisers, shift register, bit counter, pointers, fifo_count, overflow SHALL clear to 0, FSM to OFF; rd_valid=0, panel_on=0, rd_data=0, rd_is_data=0.
REQ-028 Release of cpu_resetn mid-byte SHALL start capture at the next complete byte after FSM reaches IDLE; no spurious push.

Structure
REQ-029 Shared package SHALL hold the FSM state enumeration (OFF, IDLE, SHIFT) and the FIFO entry width constant (9 bits: dc + byte).
REQ-030 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width and depth; capture logic stays in oled_spi_sink.

Verification
REQ-031 Power on (vdd=vbat=0, res=1), send 0xAE with dc=0 at sysclk/8 -> one entry rd_data=0xAE, rd_is_data=0, rd_valid 4 cycles after last edge.
REQ-032 Send 0x81,0x7F with dc=0 then 0x55 with dc=1, rd_ready=1 -> three pops in order with dc flags 0,0,1.
REQ-033 rd_ready=0, send 17 bytes 0x00..0x10 (depth 16) -> fifo_count=16, overflow=1, pops yield 0x00..0x0F.
REQ-034 Send 5 bits, pulse oled_res low 4 cycles, then send 0xA5 -> single entry 0xA5.
REQ-035 Full FIFO, rd_ready=1 on the cycle of a push -> count stays 16, overflow stays 0.
REQ-036 Assert cpu_resetn low mid-byte with 3 entries queued -> rd_valid=0, fifo_count=0, overflow=0 immediately; next full byte captured correctly.
